// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grants and a
// hold-limit counter that forces rotation while other requesters are waiting.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic r0,
  input  logic r1,
  input  logic r2,
  input  logic r3,
  output logic g0,
  output logic g1,
  output logic g2,
  output logic g3,
  output logic gv
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_last;
  logic [1:0]  w_last_next;
  logic [7:0]  r_hcnt;
  logic [7:0]  w_hcnt_next;
  logic [3:0]  r_grant;
  logic [3:0]  w_grant_next;
  logic        r_gv;

  logic [3:0]  w_req;
  logic [1:0]  w_owner;
  logic        w_owner_req;
  logic        w_others;
  logic [3:0]  w_pick_idle;
  logic [3:0]  w_pick_rot;

  // First asserted request at or after 'start', wrapping mod 4; one-hot result.
  function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [3:0] sel;
    logic [1:0] idx;
    logic       found;
    sel   = 4'b0000;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + i[1:0];
      if (!found && req[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return sel;
  endfunction

  assign w_req = {r3, r2, r1, r0};

  always_comb begin
    w_owner = 2'd0;
    case (r_grant)
      4'b0010: w_owner = 2'd1;
      4'b0100: w_owner = 2'd2;
      4'b1000: w_owner = 2'd3;
      default: w_owner = 2'd0;
    endcase
  end

  assign w_owner_req = |(w_req & r_grant);
  assign w_others    = |(w_req & ~r_grant);
  assign w_pick_idle = rr_pick(w_req, r_last + 2'd1);
  // The current owner is masked out, so a forced rotation never re-grants it.
  assign w_pick_rot  = rr_pick(w_req & ~r_grant, w_owner + 2'd1);

  always_comb begin
    w_state_next = r_state;
    w_last_next  = r_last;
    w_hcnt_next  = r_hcnt;
    w_grant_next = r_grant;
    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_grant_next = w_pick_idle;
          w_state_next = GRANT;
          w_hcnt_next  = 8'd0;
        end
      end
      GRANT: begin
        if (w_owner_req) begin
          if (!w_others) begin
            w_hcnt_next = (r_hcnt >= HOLD_LIM) ? HOLD_LIM : r_hcnt + 8'd1;
          end else if (r_hcnt < HOLD_LIM) begin
            w_hcnt_next = r_hcnt + 8'd1;
          end else begin
            w_last_next  = w_owner;
            w_grant_next = w_pick_rot;
            w_hcnt_next  = 8'd0;
          end
        end else begin
          w_last_next = w_owner;
          w_hcnt_next = 8'd0;
          if (w_others) begin
            w_grant_next = w_pick_rot;
          end else begin
            w_grant_next = 4'b0000;
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_grant_next = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 2'd3;
      r_hcnt  <= 8'd0;
      r_grant <= 4'b0000;
      r_gv    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_last  <= w_last_next;
      r_hcnt  <= w_hcnt_next;
      r_grant <= w_grant_next;
      r_gv    <= (w_state_next == GRANT);
    end
  end

  assign g0 = r_grant[0];
  assign g1 = r_grant[1];
  assign g2 = r_grant[2];
  assign g3 = r_grant[3];
  assign gv = r_gv;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: two instances (MAX_HOLD 8 and 1) share the request
// inputs and are checked against a queue-free owner/last/hold reference model.
module tb_rr_arbiter4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic r0 = 1'b0, r1 = 1'b0, r2 = 1'b0, r3 = 1'b0;
  logic a_g0, a_g1, a_g2, a_g3, a_gv;
  logic b_g0, b_g1, b_g2, b_g3, b_gv;

  int n_checks = 0;
  int n_fail   = 0;

  int m_owner [2];
  int m_last  [2];
  int m_hold  [2];
  int m_limit [2] = '{8, 1};

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(8)) dut_a (
    .clk(clk), .rst(rst), .r0(r0), .r1(r1), .r2(r2), .r3(r3),
    .g0(a_g0), .g1(a_g1), .g2(a_g2), .g3(a_g3), .gv(a_gv)
  );

  rr_arbiter4 #(.MAX_HOLD(1)) dut_b (
    .clk(clk), .rst(rst), .r0(r0), .r1(r1), .r2(r2), .r3(r3),
    .g0(b_g0), .g1(b_g1), .g2(b_g2), .g3(b_g3), .gv(b_gv)
  );

  typedef struct {
    logic [3:0] req;
    logic [4:0] exp;   // {gv, g3, g2, g1, g0}
  } vec_t;

  function automatic logic [4:0] act_of(input int d);
    if (d == 0) return {a_gv, a_g3, a_g2, a_g1, a_g0};
    return {b_gv, b_g3, b_g2, b_g1, b_g0};
  endfunction

  function automatic logic [4:0] exp_of(input int d);
    logic [4:0] v;
    v = 5'b00000;
    if (m_owner[d] >= 0) begin
      v[m_owner[d]] = 1'b1;
      v[4] = 1'b1;
    end
    return v;
  endfunction

  // Index of the first requester (not 'excl') at or after 'start', mod 4; -1 if none.
  function automatic int pick(input int start, input logic [3:0] req, input int excl);
    for (int i = 0; i < 4; i++) begin
      int idx;
      idx = (start + i) % 4;
      if (req[idx] && idx != excl) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_last[d]  = 3;
      m_hold[d]  = 0;
    end
  endtask

  task automatic model_step(input int d, input logic [3:0] req);
    int k;
    int lim;
    k   = m_owner[d];
    lim = m_limit[d] - 1;
    if (k < 0) begin
      m_owner[d] = pick(m_last[d] + 1, req, -1);
      m_hold[d]  = 0;
    end else if (req[k]) begin
      if (pick(k + 1, req, k) < 0) begin
        if (m_hold[d] < lim) m_hold[d]++;
      end else if (m_hold[d] < lim) begin
        m_hold[d]++;
      end else begin
        m_last[d]  = k;
        m_owner[d] = pick(k + 1, req, k);
        m_hold[d]  = 0;
      end
    end else begin
      m_last[d]  = k;
      m_owner[d] = pick(k + 1, req, k);
      m_hold[d]  = 0;
    end
  endtask

  task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got gv,g3..g0=%b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] v);
    {r3, r2, r1, r0} = v;
  endtask

  // One clock: both models see the edge-sampled requests, outputs checked 1 time unit later.
  task automatic step(input string nm);
    logic [3:0] req;
    @(posedge clk);
    req = {r3, r2, r1, r0};
    for (int d = 0; d < 2; d++) model_step(d, req);
    #1;
    check({nm, "_h8"}, act_of(0), exp_of(0));
    check({nm, "_h1"}, act_of(1), exp_of(1));
    $display("%s req=%b grant_h8=%b grant_h1=%b", nm, req, act_of(0), act_of(1));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    #2;
    check("reset_pulse_h8", act_of(0), 5'b00000);
    check("reset_pulse_h1", act_of(1), 5'b00000);
    rst = 1'b0;
  endtask

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{4'b0000, 5'b00000};
    vecs[1]  = '{4'b1000, 5'b11000};  // r3 alone after reset
    vecs[2]  = '{4'b1000, 5'b11000};
    vecs[3]  = '{4'b0000, 5'b00000};
    vecs[4]  = '{4'b0010, 5'b10010};
    vecs[5]  = '{4'b1011, 5'b10010};
    vecs[6]  = '{4'b1001, 5'b11000};  // r1 drops, search from 2 finds r3
    vecs[7]  = '{4'b0001, 5'b10001};
    vecs[8]  = '{4'b0010, 5'b10010};  // r0 release meets r1 rise, no bubble
    vecs[9]  = '{4'b0000, 5'b00000};
    vecs[10] = '{4'b0100, 5'b10100};
    vecs[11] = '{4'b0101, 5'b10100};

    model_reset();
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      drive(4'($urandom_range(0, 15)));
      check("in_reset_h8", act_of(0), 5'b00000);
      check("in_reset_h1", act_of(1), 5'b00000);
    end
    drive(4'b0000);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].req);
      step($sformatf("table%0d", i));
      check($sformatf("table%0d_const", i), act_of(0), vecs[i].exp);
    end

    pulse_reset();
    drive(4'b0100);
    for (int c = 0; c < 20; c++) begin
      step($sformatf("single_r2_%0d", c));
      check("single_r2_const", act_of(0), 5'b10100);
    end
    drive(4'b0000);
    step("single_r2_drop");
    check("single_r2_drop_const", act_of(0), 5'b00000);

    pulse_reset();
    drive(4'b1111);
    for (int c = 0; c < 40; c++) begin
      logic [4:0] e8, e1;
      e8 = 5'b10000; e8[(c / 8) % 4] = 1'b1;
      e1 = 5'b10000; e1[c % 4] = 1'b1;
      step($sformatf("contend_%0d", c));
      check("contend_h8_const", act_of(0), e8);
      check("contend_h1_const", act_of(1), e1);
    end

    pulse_reset();
    drive(4'b0100);
    step("async_setup");
    check("async_setup_const", act_of(0), 5'b10100);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_mid_h8", act_of(0), 5'b00000);
    check("async_mid_h1", act_of(1), 5'b00000);
    #1;
    rst = 1'b0;
    drive(4'b1111);
    step("async_after");
    check("async_after_const", act_of(0), 5'b10001);

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) drive(4'($urandom_range(0, 15)));
      step($sformatf("rand_%0d", c));
      check("rand_onehot_h8", 5'($countones(act_of(0) & 5'b01111) <= 1), 5'b00001);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
